// File: rtl/ahb_cfg_pkg.sv
// Shared AHB-Lite encodings, register bit positions and the error-response FSM
// state type for the MFCC configuration register file.
package ahb_cfg_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [1:0] {
        ERR_ST_OKAY = 2'd0,
        ERR_ST_ERR1 = 2'd1,
        ERR_ST_ERR2 = 2'd2
    } err_state_e;

    // Byte-lane merge: strobed bytes come from new_w, the rest keep old_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_cfg_strobe_gen.sv
// Converts an AHB transfer size and low address bits into byte-lane strobes,
// flagging halfword/word transfers that are not naturally aligned.
module ahb_cfg_strobe_gen
    import ahb_cfg_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] strb_o,
    output logic       misalign_o
);

    // Size/offset decode; unsupported sizes produce no strobes
    always_comb begin
        strb_o     = 4'b0000;
        misalign_o = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: begin
                strb_o = 4'b0001 << addr_lo_i;
            end
            HSIZE_HALF: begin
                strb_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_lo_i[0];
            end
            HSIZE_WORD: begin
                strb_o     = 4'b1111;
                misalign_o = |addr_lo_i;
            end
            default: begin
                strb_o     = 4'b0000;
                misalign_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_cfg_regfile.sv
// AHB-Lite configuration register file for the MFCC pipeline: config words,
// CTRL (start/irq enable) and STATUS (busy/sticky done). Define
// AHB_CFG_ERR_RESP_EN to get two-cycle ERROR responses on illegal transfers.
module ahb_cfg_regfile
    import ahb_cfg_pkg::*;
#(
    parameter int NUM_CFG = 10,
    parameter int ADDR_W  = 12
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic                   hsel_i,
    input  logic [1:0]             htrans_i,
    input  logic [ADDR_W-1:0]      haddr_i,
    input  logic                   hwrite_i,
    input  logic [2:0]             hsize_i,
    input  logic [31:0]            hwdata_i,
    input  logic                   hready_in_i,
    output logic [31:0]            hrdata_o,
    output logic                   hready_out_o,
    output logic [1:0]             hresp_o,
    output logic [NUM_CFG*32-1:0]  cfg_flat_o,
    output logic                   start_o,
    input  logic                   core_busy_i,
    input  logic                   core_done_i,
    output logic                   irq_o
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] CTRL_IDX   = IDX_W'(NUM_CFG);
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_CFG + 1);

    logic                    accept_s;
    logic                    err_s;
    logic                    ap_misalign_s;
    logic [3:0]              ap_strb_s;
    logic [IDX_W-1:0]        ap_idx_s;
    logic [31:0]             rdata_s;

    logic                    dp_wr_q;
    logic [IDX_W-1:0]        dp_idx_q;
    logic [3:0]              dp_strb_q;

    logic [NUM_CFG-1:0][31:0] cfg_q, cfg_d;
    logic                    irq_en_q, irq_en_d;
    logic                    done_q, done_d;
    logic                    start_q, start_d;
    logic                    irq_q;
    logic [31:0]             hrdata_q;

    assign ap_idx_s = haddr_i[ADDR_W-1:2];
    assign accept_s = hsel_i & ((htrans_i == HTRANS_NONSEQ) | (htrans_i == HTRANS_SEQ))
                      & hready_in_i & hready_out_o;
    assign err_s    = (ap_idx_s > STATUS_IDX) | (hsize_i > HSIZE_WORD) | ap_misalign_s;

    ahb_cfg_strobe_gen u_strobe_gen (
        .hsize_i    (hsize_i),
        .addr_lo_i  (haddr_i[1:0]),
        .strb_o     (ap_strb_s),
        .misalign_o (ap_misalign_s)
    );

    // Address-phase capture of the pending write; error transfers never reach the data phase
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_wr_q   <= 1'b0;
            dp_idx_q  <= '0;
            dp_strb_q <= 4'b0000;
        end else begin
            dp_wr_q <= accept_s & hwrite_i & ~err_s;
            if (accept_s) begin
                dp_idx_q  <= ap_idx_s;
                dp_strb_q <= ap_strb_s;
            end
        end
    end

    // Data-phase write merge, start generation and sticky DONE (set beats clear)
    always_comb begin
        cfg_d    = cfg_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        start_d  = 1'b0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (dp_wr_q && (dp_idx_q == IDX_W'(i))) begin
                cfg_d[i] = merge_bytes(cfg_q[i], hwdata_i, dp_strb_q);
            end else begin
                cfg_d[i] = cfg_q[i];
            end
        end
        if (dp_wr_q && (dp_idx_q == CTRL_IDX) && dp_strb_q[0]) begin
            irq_en_d = hwdata_i[CTRL_IRQ_EN_BIT];
            start_d  = hwdata_i[CTRL_START_BIT] & ~core_busy_i;
        end else begin
            irq_en_d = irq_en_q;
            start_d  = 1'b0;
        end
        if (core_done_i) begin
            done_d = 1'b1;
        end else if (dp_wr_q && (dp_idx_q == STATUS_IDX) && dp_strb_q[0]
                     && hwdata_i[STATUS_DONE_BIT]) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    // Read mux works on next-state values so a read right behind a write sees the new data
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (err_s) begin
            rdata_s = 32'h0000_0000;
        end else if (ap_idx_s == CTRL_IDX) begin
            rdata_s[CTRL_IRQ_EN_BIT] = irq_en_d;
        end else if (ap_idx_s == STATUS_IDX) begin
            rdata_s[STATUS_BUSY_BIT] = core_busy_i;
            rdata_s[STATUS_DONE_BIT] = done_d;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                rdata_s = rdata_s | ((ap_idx_s == IDX_W'(i)) ? cfg_d[i] : 32'h0000_0000);
            end
        end
    end

    // Architectural registers and registered outputs
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cfg_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
            hrdata_q <= 32'h0000_0000;
        end else begin
            cfg_q    <= cfg_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            start_q  <= start_d;
            irq_q    <= done_d & irq_en_d;
            if (accept_s && !hwrite_i) begin
                hrdata_q <= rdata_s;
            end
        end
    end

`ifdef AHB_CFG_ERR_RESP_EN
    err_state_e  state_q, state_d;
    logic        hready_out_q;
    logic [1:0]  hresp_q;

    // Two-cycle ERROR response sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ERR_ST_OKAY: state_d = (accept_s && err_s) ? ERR_ST_ERR1 : ERR_ST_OKAY;
            ERR_ST_ERR1: state_d = ERR_ST_ERR2;
            ERR_ST_ERR2: state_d = (accept_s && err_s) ? ERR_ST_ERR1 : ERR_ST_OKAY;
            default:     state_d = ERR_ST_OKAY;
        endcase
    end

    // Response outputs registered from the next state
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ERR_ST_OKAY;
            hready_out_q <= 1'b1;
            hresp_q      <= HRESP_OKAY;
        end else begin
            state_q      <= state_d;
            hready_out_q <= (state_d != ERR_ST_ERR1);
            hresp_q      <= (state_d == ERR_ST_OKAY) ? HRESP_OKAY : HRESP_ERROR;
        end
    end

    assign hready_out_o = hready_out_q;
    assign hresp_o      = hresp_q;
`else
    assign hready_out_o = 1'b1;
    assign hresp_o      = HRESP_OKAY;
`endif

    assign hrdata_o   = hrdata_q;
    assign cfg_flat_o = cfg_q;
    assign start_o    = start_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_ahb_cfg_regfile.sv
// Scoreboard bench for ahb_cfg_regfile: the driver queues the expected data-phase
// response of every accepted transfer; a bus monitor pops and compares it.
module tb_ahb_cfg_regfile;
    import ahb_cfg_pkg::*;

    localparam int NUM_CFG = 10;
    localparam int ADDR_W  = 12;
`ifdef AHB_CFG_ERR_RESP_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic                  hclk = 1'b0;
    logic                  hresetn = 1'b0;
    logic                  hsel = 1'b0;
    logic [1:0]            htrans = HTRANS_IDLE;
    logic [ADDR_W-1:0]     haddr = '0;
    logic                  hwrite = 1'b0;
    logic [2:0]            hsize = HSIZE_WORD;
    logic [31:0]           hwdata = 32'h0;
    logic                  hready_in = 1'b1;
    logic [31:0]           hrdata;
    logic                  hready_out;
    logic [1:0]            hresp;
    logic [NUM_CFG*32-1:0] cfg_flat;
    logic                  start;
    logic                  core_busy = 1'b0;
    logic                  core_done = 1'b0;
    logic                  irq;

    ahb_cfg_regfile #(.NUM_CFG(NUM_CFG), .ADDR_W(ADDR_W)) dut (
        .hclk         (hclk),
        .hresetn      (hresetn),
        .hsel_i       (hsel),
        .htrans_i     (htrans),
        .haddr_i      (haddr),
        .hwrite_i     (hwrite),
        .hsize_i      (hsize),
        .hwdata_i     (hwdata),
        .hready_in_i  (hready_in),
        .hrdata_o     (hrdata),
        .hready_out_o (hready_out),
        .hresp_o      (hresp),
        .cfg_flat_o   (cfg_flat),
        .start_o      (start),
        .core_busy_i  (core_busy),
        .core_done_i  (core_done),
        .irq_o        (irq)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] pend_wdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the address phase is accepted.
    task automatic drive(input logic [1:0] tr, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [2:0] sz, input logic [31:0] wd,
                         input logic [31:0] rd_exp, input logic err);
        int   guard;
        exp_t e;
        hsel   = (tr != HTRANS_IDLE);
        htrans = tr;
        hwrite = wr;
        haddr  = addr;
        hsize  = sz;
        hwdata = pend_wdata;
        pend_wdata = wd;
        if (hsel && tr[1] && hready_in) begin
            e.is_read = ~wr;
            e.rdata   = rd_exp;
            e.err     = err;
            exp_q.push_back(e);
        end
        guard = 0;
        @(negedge hclk);
        while (!hready_out && guard < 16) begin
            guard++;
            @(negedge hclk);
        end
        if (guard >= 16) chk("hready_timeout", {31'b0, hready_out}, 32'h1);
        @(posedge hclk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] addr, input logic [2:0] sz,
                      input logic [31:0] data, input logic err);
        drive(HTRANS_NONSEQ, 1'b1, addr, sz, data, 32'h0, err);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] addr, input logic [31:0] expv, input logic err);
        drive(HTRANS_NONSEQ, 1'b0, addr, HSIZE_WORD, 32'h0, expv, err);
    endtask

    task automatic idle();
        drive(HTRANS_IDLE, 1'b0, '0, HSIZE_WORD, 32'h0, 32'h0, 1'b0);
    endtask

    // Bus monitor: pops the expectation at accept, checks it across the data phase
    initial begin : monitor
        exp_t cur;
        logic act;
        logic stage;
        act   = 1'b0;
        stage = 1'b0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                act   = 1'b0;
                stage = 1'b0;
            end else begin
                if (act) begin
                    if (cur.err && !stage) begin
                        chk("err1_hready", {31'b0, hready_out}, 32'h0);
                        chk("err1_hresp", {30'b0, hresp}, {30'b0, HRESP_ERROR});
                        stage = 1'b1;
                    end else begin
                        chk("dp_hready", {31'b0, hready_out}, 32'h1);
                        chk("dp_hresp", {30'b0, hresp},
                            {30'b0, (cur.err ? HRESP_ERROR : HRESP_OKAY)});
                        if (cur.is_read && !cur.err) chk("rdata", hrdata, cur.rdata);
                        act = 1'b0;
                    end
                end
                if (!act && hsel && htrans[1] && hready_in && hready_out) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_underflow", 32'h1, 32'h0);
                    end else begin
                        cur   = exp_q.pop_front();
                        act   = 1'b1;
                        stage = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_hready", {31'b0, hready_out}, 32'h1);
        chk("rst_hresp", {30'b0, hresp}, 32'h0);
        chk("rst_start", {31'b0, start}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_cfg_flat", {31'b0, |cfg_flat}, 32'h0);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // every word reads zero after reset
        for (int i = 0; i < NUM_CFG + 2; i++) rd(ADDR_W'(4 * i), 32'h0, 1'b0);
        idle();

        // word write, byte-lane write, read with forwarding
        wr(12'h00C, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0);
        wr(12'h00D, HSIZE_BYTE, 32'hAAAA_55AA, 1'b0);
        rd(12'h00C, 32'hDEAD_55EF, 1'b0);
        wr(12'h012, HSIZE_HALF, 32'hCAFE_9999, 1'b0);
        rd(12'h010, 32'hCAFE_0000, 1'b0);
        wr(12'h000, HSIZE_WORD, 32'h1234_5678, 1'b0);
        rd(12'h000, 32'h1234_5678, 1'b0);
        idle();
        chk("cfg_word3", cfg_flat[3*32 +: 32], 32'hDEAD_55EF);
        chk("cfg_word0", cfg_flat[0 +: 32], 32'h1234_5678);

        // hready_in low: no capture
        hready_in = 1'b0;
        wr(12'h004, HSIZE_WORD, 32'hFFFF_FFFF, 1'b0);
        hready_in = 1'b1;
        rd(12'h004, 32'h0, 1'b0);

        // sequential burst across last config word into CTRL/STATUS, with a BUSY beat
        drive(HTRANS_NONSEQ, 1'b0, 12'h024, HSIZE_WORD, 32'h0, 32'h0, 1'b0);
        drive(HTRANS_BUSY,   1'b0, 12'h028, HSIZE_WORD, 32'h0, 32'h0, 1'b0);
        drive(HTRANS_SEQ,    1'b0, 12'h028, HSIZE_WORD, 32'h0, 32'h0, 1'b0);
        drive(HTRANS_SEQ,    1'b0, 12'h02C, HSIZE_WORD, 32'h0, 32'h0, 1'b0);
        idle();

        // start pulse and irq enable
        wr(12'h028, HSIZE_WORD, 32'h0000_0003, 1'b0);
        chk("start_early", {31'b0, start}, 32'h0);
        idle();
        chk("start_pulse", {31'b0, start}, 32'h1);
        @(posedge hclk);
        #1;
        chk("start_clear", {31'b0, start}, 32'h0);
        rd(12'h028, 32'h0000_0002, 1'b0);
        idle();

        // core_done sets DONE and irq
        core_done = 1'b1;
        @(posedge hclk);
        #1;
        core_done = 1'b0;
        chk("irq_set", {31'b0, irq}, 32'h1);
        rd(12'h02C, 32'h0000_0002, 1'b0);
        idle();

        // W1C colliding with core_done: set wins
        wr(12'h02C, HSIZE_WORD, 32'h0000_0002, 1'b0);
        core_done = 1'b1;
        idle();
        core_done = 1'b0;
        chk("irq_set_wins", {31'b0, irq}, 32'h1);
        rd(12'h02C, 32'h0000_0002, 1'b0);
        wr(12'h02C, HSIZE_WORD, 32'h0000_0002, 1'b0);
        idle();
        chk("irq_cleared", {31'b0, irq}, 32'h0);
        rd(12'h02C, 32'h0, 1'b0);
        idle();

        // start suppressed while core busy; BUSY mirrors core_busy
        core_busy = 1'b1;
        wr(12'h028, HSIZE_WORD, 32'h0000_0003, 1'b0);
        idle();
        chk("start_suppressed", {31'b0, start}, 32'h0);
        rd(12'h02C, 32'h0000_0001, 1'b0);
        chk("start_suppressed2", {31'b0, start}, 32'h0);
        idle();
        core_busy = 1'b0;

        // error transfers: out of range, misaligned, oversize; no side effects
        wr(12'h030, HSIZE_WORD, 32'hFFFF_FFFF, ERR_EN);
        rd(12'h030, 32'h0, ERR_EN);
        wr(12'h00E, HSIZE_WORD, 32'h1111_1111, ERR_EN);
        rd(12'h00C, 32'hDEAD_55EF, 1'b0);
        drive(HTRANS_NONSEQ, 1'b1, 12'h000, 3'd3, 32'hFFFF_FFFF, 32'h0, ERR_EN);
        rd(12'h000, 32'h1234_5678, 1'b0);
        wr(12'h011, HSIZE_HALF, 32'h7777_7777, ERR_EN);
        rd(12'h010, 32'hCAFE_0000, 1'b0);
        idle();
        idle();
        chk("err_no_change", cfg_flat[4*32 +: 32], 32'hCAFE_0000);

        // asynchronous reset during a write data phase
        wr(12'h004, HSIZE_WORD, 32'hA5A5_A5A5, 1'b0);
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwdata = pend_wdata;
        pend_wdata = 32'h0;
        #2;
        hresetn = 1'b0;
        #1;
        chk("arst_cfg_flat", {31'b0, |cfg_flat}, 32'h0);
        chk("arst_hrdata", hrdata, 32'h0);
        chk("arst_hready", {31'b0, hready_out}, 32'h1);
        chk("arst_hresp", {30'b0, hresp}, 32'h0);
        @(posedge hclk);
        #1;
        chk("arst_discard", {31'b0, |cfg_flat}, 32'h0);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        rd(12'h004, 32'h0, 1'b0);
        rd(12'h028, 32'h0, 1'b0);
        idle();
        idle();

        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
